aes_inv_cipher_iter: RTL and testbench

- Iterative AES inverse cipher core that decrypts one 128-bit block per transaction.
- Supports AES-128, AES-192 and AES-256 through the NR parameter.
- Runs a configurable number of inverse S-box lanes in parallel, trading area for latency.
- Sits after the key-schedule RAM. It reads round keys by index and exchanges blocks over valid/ready handshakes with upstream and downstream logic.

---
 rtl/aes_inv_cipher_iter.sv | 216 +++++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_iter
//
// Iterative AES inverse cipher. Decrypts one 128-bit block per transaction
// using round keys read by index from an external key-schedule RAM.
//
// Each round spends S = 16/LANES cycles applying the inverse S-box to LANES
// bytes per cycle (SUB). It then spends one cycle on InvShiftRows,
// AddRoundKey and InvMixColumns (MIX). InvSubBytes is done before
// InvShiftRows because the two operations commute.
//
// Parameters
//   NR     number of rounds: 10, 12 or 14 (AES-128/192/256)
//   LANES  inverse S-box instances used per cycle: 1, 2, 4, 8 or 16
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   ciphertext block offered
//   in_ready   core idle and able to accept a block
//   in_data    ciphertext block
//   rk_idx     round-key index presented to the key RAM
//   rk_data    round key rk[rk_idx], valid combinationally in the same cycle
//   out_valid  plaintext block available
//   out_ready  downstream takes the plaintext block
//   out_data   plaintext block; holds the last completed result
//   busy       core is not idle
//
// Byte i of a block is bits [127-8i -: 8]. The state is column-major, so
// byte i sits at row i%4, column i/4.
// -----------------------------------------------------------------------------
`default_nettype none

module aes_inv_cipher_iter #(
    parameter int NR    = 10,
    parameter int LANES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int S  = 16 / LANES;
    localparam int KW = (S > 1) ? $clog2(S) : 1;

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_inv_cipher_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse S-box; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;

    fsm_t           r_fsm;
    logic [3:0]     r_round;
    logic [KW-1:0]  r_k;
    logic [127:0]   r_state;
    logic [127:0]   r_out;

    logic [127:0]   w_sub;
    logic [127:0]   w_t;
    logic [127:0]   w_mix;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times the inverse MixColumns matrix {0e,0b,0d,09}.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a  = col[31-8*i -: 8];
            x2 = xt(a);
            x4 = xt(x2);
            x8 = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    // Substitute the LANES bytes selected by the lane counter, leave the rest.
    always_comb begin
        // NOTE: full default before the partial updates keeps this purely
        // combinational; a missing default would infer a latch.
        w_sub = r_state;
        for (int j = 0; j < LANES; j++) begin
            w_sub[127-8*(int'(r_k)*LANES+j) -: 8] =
                INV_SBOX[r_state[127-8*(int'(r_k)*LANES+j) -: 8]];
        end
    end

    assign w_t   = inv_shift_rows(r_state) ^ rk_data;
    assign w_mix = inv_mix_cols(w_t);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // sees the pre-edge values of the others, whatever the statement order.
        if (rst) begin
            r_fsm   <= IDLE;
            r_round <= '0;
            r_k     <= '0;
            r_state <= '0;
            r_out   <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data ^ rk_data;
                        r_round <= 4'(NR - 1);
                        r_k     <= '0;
                        r_fsm   <= SUB;
                    end
                end
                SUB: begin
                    r_state <= w_sub;
                    if (r_k == KW'(S - 1)) begin
                        r_fsm <= MIX;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                MIX: begin
                    if (r_round != 4'd0) begin
                        r_state <= w_mix;
                        r_round <= r_round - 1'b1;
                        r_k     <= '0;
                        r_fsm   <= SUB;
                    end else begin
                        // Final round has no InvMixColumns.
                        r_out <= w_t;
                        r_fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE) && !rst;
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm != IDLE);
    assign out_data  = r_out;
    // The key RAM sees the final-round index whenever no round is in progress,
    // so rk[NR] is already on rk_data when a block is accepted.
    assign rk_idx    = (r_fsm == SUB || r_fsm == MIX) ? r_round : 4'(NR);

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
//
// Four instances cover NR=10/LANES=16, NR=12/LANES=4, NR=12/LANES=1 and
// NR=14/LANES=8. Round keys are expanded here from the cipher key. Expected
// plaintexts are published known-answer values pushed into a scoreboard queue
// when a block is accepted and popped when out_valid rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_inv_cipher_iter;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192    = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0][127:0] in_data, rk_data, out_data;
    logic [3:0][3:0]   rk_idx;

    logic [127:0] rk_tab [4][16];
    logic [127:0] sb_q [$];
    int n_cmp = 0;
    int n_mis = 0;

    int unr [4] = '{10, 12, 12, 14};
    int us  [4] = '{1, 4, 16, 2};
    logic [127:0] ct_kat [4] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                 128'h8ea2b7ca516745bfeafc49904b496089};
    logic [127:0] ct_sp [4] = '{128'h3925841d02dc09fbdc118597196a0b32,
                                128'h3ad77bb40d7a3660a89ecaf32466ef97,
                                128'hf5d3d58503b9699de785895a96fdbaaf,
                                128'h7b0c785e27e8ad3f8223207104725dd4};
    logic [127:0] pt_sp [4] = '{128'h3243f6a8885a308d313198a2e0370734,
                                128'h6bc1bee22e409f96e93d7e117393172a,
                                128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'hf69f2445df4f9b17ad2b417be66c3710};

    aes_inv_cipher_iter #(.NR(10), .LANES(16)) u_dut0 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]));
    aes_inv_cipher_iter #(.NR(12), .LANES(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]));
    aes_inv_cipher_iter #(.NR(12), .LANES(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .rk_idx(rk_idx[2]), .rk_data(rk_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2]));
    aes_inv_cipher_iter #(.NR(14), .LANES(8)) u_dut3 (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .rk_idx(rk_idx[3]), .rk_data(rk_data[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
        .busy(busy[3]));

    // Key RAM model: combinational read.
    assign rk_data[0] = rk_tab[0][rk_idx[0]];
    assign rk_data[1] = rk_tab[1][rk_idx[1]];
    assign rk_data[2] = rk_tab[2][rk_idx[2]];
    assign rk_data[3] = rk_tab[3][rk_idx[3]];

    // ---------------- forward S-box and key expansion ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    task automatic expand(input int u, input logic [255:0] key, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int nk;
        nk   = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) rk_tab[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer a block and return at the negedge after the accepting edge.
    task automatic accept(input int u, input logic [127:0] ct, input logic [127:0] pt, input bit keep);
        int n;
        n = 0;
        in_data[u]  = ct;
        in_valid[u] = 1'b1;
        while (!in_ready[u] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d in_ready before accept", u), 128'(in_ready[u]), 128'd1);
        @(negedge clk);
        sb_q.push_back(pt);
        if (!keep) in_valid[u] = 1'b0;
    endtask

    // Wait for out_valid, checking rk_idx every cycle, latency and plaintext.
    task automatic wait_out(input int u, input int lat);
        int n;
        logic [127:0] exp;
        n = 0;
        check($sformatf("u%0d busy after accept", u), 128'(busy[u]), 128'd1);
        check($sformatf("u%0d in_ready after accept", u), 128'(in_ready[u]), 128'd0);
        while (!out_valid[u] && n < lat + 50) begin
            if (n < lat)
                check($sformatf("u%0d rk_idx cyc %0d", u, n), 128'(rk_idx[u]),
                      128'(unr[u] - 1 - n / (us[u] + 1)));
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d out_valid seen", u), 128'(out_valid[u]), 128'd1);
        check($sformatf("u%0d latency", u), 128'(n), 128'(lat));
        check($sformatf("u%0d rk_idx in DONE", u), 128'(rk_idx[u]), 128'(unr[u]));
        check($sformatf("u%0d scoreboard nonempty", u), 128'(sb_q.size() > 0), 128'd1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check($sformatf("u%0d out_data", u), out_data[u], exp);
        end
    endtask

    // One cycle after DONE with out_ready high: back in IDLE, result held.
    task automatic post_idle(input int u, input logic [127:0] pt);
        @(negedge clk);
        check($sformatf("u%0d out_valid after release", u), 128'(out_valid[u]), 128'd0);
        check($sformatf("u%0d busy after release", u), 128'(busy[u]), 128'd0);
        check($sformatf("u%0d in_ready after release", u), 128'(in_ready[u]), 128'd1);
        check($sformatf("u%0d rk_idx idle", u), 128'(rk_idx[u]), 128'(unr[u]));
        check($sformatf("u%0d out_data held", u), out_data[u], pt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (%0d compared)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t_prev, t_now;
        t_prev = 0;
        rst       = 4'hf;
        in_valid  = 4'h0;
        in_data   = '0;
        out_ready = 4'hf;
        for (int u = 0; u < 4; u++)
            for (int r = 0; r < 16; r++) rk_tab[u][r] = '0;
        expand(0, {K128, 128'h0}, 10);
        expand(1, {K192, 64'h0}, 12);
        expand(2, {K192, 64'h0}, 12);
        expand(3, K256, 14);

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("u%0d reset in_ready", u), 128'(in_ready[u]), 128'd0);
            check($sformatf("u%0d reset out_valid", u), 128'(out_valid[u]), 128'd0);
            check($sformatf("u%0d reset busy", u), 128'(busy[u]), 128'd0);
            check($sformatf("u%0d reset out_data", u), out_data[u], 128'd0);
            check($sformatf("u%0d reset rk_idx", u), 128'(rk_idx[u]), 128'(unr[u]));
        end
        rst = 4'h0;
        @(negedge clk);
        for (int u = 0; u < 4; u++)
            check($sformatf("u%0d in_ready after reset", u), 128'(in_ready[u]), 128'd1);

        // Known-answer decrypts for every configuration.
        for (int u = 0; u < 4; u++) begin
            accept(u, ct_kat[u], PT_FIPS, 1'b0);
            wait_out(u, unr[u] * (us[u] + 1));
            post_idle(u, PT_FIPS);
        end

        // Backpressure on unit 0 with a second block pending.
        expand(0, {K_SP, 128'h0}, 10);
        out_ready[0] = 1'b0;
        accept(0, ct_sp[0], pt_sp[0], 1'b1);
        in_data[0] = ct_sp[1];
        wait_out(0, 20);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("bp out_valid %0d", i), 128'(out_valid[0]), 128'd1);
            check($sformatf("bp out_data %0d", i), out_data[0], pt_sp[0]);
            check($sformatf("bp in_ready %0d", i), 128'(in_ready[0]), 128'd0);
        end
        out_ready[0] = 1'b1;
        post_idle(0, pt_sp[0]);
        accept(0, ct_sp[1], pt_sp[1], 1'b0);
        wait_out(0, 20);
        post_idle(0, pt_sp[1]);

        // Reset in the middle of a block.
        accept(0, ct_sp[2], pt_sp[2], 1'b0);
        repeat (7) @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("midrst out_valid", 128'(out_valid[0]), 128'd0);
        check("midrst busy", 128'(busy[0]), 128'd0);
        check("midrst out_data", out_data[0], 128'd0);
        check("midrst in_ready", 128'(in_ready[0]), 128'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        check("midrst in_ready after", 128'(in_ready[0]), 128'd1);
        check("midrst out_valid after", 128'(out_valid[0]), 128'd0);
        accept(0, ct_sp[2], pt_sp[2], 1'b0);
        wait_out(0, 20);
        post_idle(0, pt_sp[2]);

        // Back-to-back stream with out_ready tied high.
        for (int j = 0; j < 4; j++) begin
            accept(0, ct_sp[j], pt_sp[j], j < 3);
            wait_out(0, 20);
            t_now = $time;
            if (j > 0) check($sformatf("b2b spacing %0d", j), 128'((t_now - t_prev) / 10), 128'd22);
            t_prev = t_now;
            @(negedge clk);
            check($sformatf("b2b pulse width %0d", j), 128'(out_valid[0]), 128'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
